// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register: captures decoded operands, forwards EX/MEM and MEM/WB results.
// Optional macro EX_FWD_EN enables the forwarding muxes and the stall-time operand refresh.
module id_ex_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int OP_W    = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               ID_VALID,
    input  logic [DATA_W-1:0]  ID_RS_DATA,
    input  logic [DATA_W-1:0]  ID_RT_DATA,
    input  logic [DATA_W-1:0]  ID_IMM,
    input  logic [4:0]         ID_SHAMT,
    input  logic [RADDR_W-1:0] ID_RS_ADDR,
    input  logic [RADDR_W-1:0] ID_RT_ADDR,
    input  logic               ID_A_SEL,
    input  logic [1:0]         ID_B_SEL,
    input  logic [OP_W-1:0]    ID_ALU_OP,
    input  logic [RADDR_W-1:0] ID_WR_ADDR,
    input  logic               ID_REG_WRITE,
    input  logic               STALL,
    input  logic               FLUSH,
    input  logic               MEM_REG_WRITE,
    input  logic [RADDR_W-1:0] MEM_WR_ADDR,
    input  logic [DATA_W-1:0]  MEM_RESULT,
    input  logic               WB_REG_WRITE,
    input  logic [RADDR_W-1:0] WB_WR_ADDR,
    input  logic [DATA_W-1:0]  WB_RESULT,
    output logic [DATA_W-1:0]  ALU_A,
    output logic [DATA_W-1:0]  ALU_B,
    output logic [OP_W-1:0]    ALU_OP,
    output logic               EX_VALID,
    output logic [RADDR_W-1:0] EX_WR_ADDR,
    output logic               EX_REG_WRITE,
    output logic [DATA_W-1:0]  EX_RT_FWD
);

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [RADDR_W-1:0] rs_addr;
        logic [RADDR_W-1:0] rt_addr;
        logic [DATA_W-1:0]  imm;
        logic [4:0]         shamt;
        logic               a_sel;
        logic [1:0]         b_sel;
        logic [OP_W-1:0]    alu_op;
        logic [RADDR_W-1:0] wr_addr;
        logic               reg_write;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t id_d;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    assign id_d = '{
        valid:     ID_VALID,
        rs_data:   ID_RS_DATA,
        rt_data:   ID_RT_DATA,
        rs_addr:   ID_RS_ADDR,
        rt_addr:   ID_RT_ADDR,
        imm:       ID_IMM,
        shamt:     ID_SHAMT,
        a_sel:     ID_A_SEL,
        b_sel:     ID_B_SEL,
        alu_op:    ID_ALU_OP,
        wr_addr:   ID_WR_ADDR,
        reg_write: ID_REG_WRITE
    };

`ifdef EX_FWD_EN
    // MEM is the younger producer, so it is checked before WB; $0 never forwards.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [RADDR_W-1:0] addr,
        input logic [DATA_W-1:0]  regd,
        input logic               mrw,
        input logic [RADDR_W-1:0] mwa,
        input logic [DATA_W-1:0]  mres,
        input logic               wrw,
        input logic [RADDR_W-1:0] wwa,
        input logic [DATA_W-1:0]  wres
    );
        logic [DATA_W-1:0] v;
        v = regd;
        if (addr == '0)
            v = regd;
        else if (mrw && (mwa == addr))
            v = mres;
        else if (wrw && (wwa == addr))
            v = wres;
        return v;
    endfunction

    assign fwd_rs = fwd_sel(ex_q.rs_addr, ex_q.rs_data,
                            MEM_REG_WRITE, MEM_WR_ADDR, MEM_RESULT,
                            WB_REG_WRITE, WB_WR_ADDR, WB_RESULT);
    assign fwd_rt = fwd_sel(ex_q.rt_addr, ex_q.rt_data,
                            MEM_REG_WRITE, MEM_WR_ADDR, MEM_RESULT,
                            WB_REG_WRITE, WB_WR_ADDR, WB_RESULT);
`else
    logic unused_fwd;
    assign unused_fwd = ^{MEM_REG_WRITE, MEM_WR_ADDR, MEM_RESULT,
                          WB_REG_WRITE, WB_WR_ADDR, WB_RESULT,
                          ex_q.rs_addr, ex_q.rt_addr};
    assign fwd_rs = ex_q.rs_data;
    assign fwd_rt = ex_q.rt_data;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ex_q <= '0;
        end else if (FLUSH) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.alu_op    <= '0;
            ex_q.wr_addr   <= '0;
        end else if (STALL) begin
`ifdef EX_FWD_EN
            // Capture forwarded values so a producer leaving WB is not lost.
            ex_q.rs_data <= fwd_rs;
            ex_q.rt_data <= fwd_rt;
`endif
        end else begin
            ex_q <= id_d;
        end
    end

    assign ALU_A = ex_q.a_sel ? fwd_rt : fwd_rs;

    always_comb begin
        ALU_B = '0;
        unique case (ex_q.b_sel)
            2'd0: ALU_B = fwd_rt;
            2'd1: ALU_B = ex_q.imm;
            2'd2: ALU_B = {{(DATA_W-5){1'b0}}, ex_q.shamt};
            2'd3: ALU_B = '0;
            default: ALU_B = '0;
        endcase
    end

    assign ALU_OP       = ex_q.alu_op;
    assign EX_VALID     = ex_q.valid;
    assign EX_WR_ADDR   = ex_q.wr_addr;
    assign EX_REG_WRITE = ex_q.reg_write & ex_q.valid;
    assign EX_RT_FWD    = fwd_rt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: random and directed stimulus vs a reference model.
// The model follows EX_FWD_EN the same way the design build does.
module tb_id_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ID_VALID;
    logic [31:0] ID_RS_DATA, ID_RT_DATA, ID_IMM;
    logic [4:0]  ID_SHAMT, ID_RS_ADDR, ID_RT_ADDR, ID_WR_ADDR;
    logic        ID_A_SEL;
    logic [1:0]  ID_B_SEL;
    logic [3:0]  ID_ALU_OP;
    logic        ID_REG_WRITE, STALL, FLUSH;
    logic        MEM_REG_WRITE, WB_REG_WRITE;
    logic [4:0]  MEM_WR_ADDR, WB_WR_ADDR;
    logic [31:0] MEM_RESULT, WB_RESULT;
    logic [31:0] ALU_A, ALU_B, EX_RT_FWD;
    logic [3:0]  ALU_OP;
    logic        EX_VALID, EX_REG_WRITE;
    logic [4:0]  EX_WR_ADDR;

    always #5 CLK = ~CLK;

    id_ex_operand_stage dut (
        .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID),
        .ID_RS_DATA(ID_RS_DATA), .ID_RT_DATA(ID_RT_DATA), .ID_IMM(ID_IMM),
        .ID_SHAMT(ID_SHAMT), .ID_RS_ADDR(ID_RS_ADDR), .ID_RT_ADDR(ID_RT_ADDR),
        .ID_A_SEL(ID_A_SEL), .ID_B_SEL(ID_B_SEL), .ID_ALU_OP(ID_ALU_OP),
        .ID_WR_ADDR(ID_WR_ADDR), .ID_REG_WRITE(ID_REG_WRITE),
        .STALL(STALL), .FLUSH(FLUSH),
        .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_WR_ADDR(MEM_WR_ADDR), .MEM_RESULT(MEM_RESULT),
        .WB_REG_WRITE(WB_REG_WRITE), .WB_WR_ADDR(WB_WR_ADDR), .WB_RESULT(WB_RESULT),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .EX_VALID(EX_VALID),
        .EX_WR_ADDR(EX_WR_ADDR), .EX_REG_WRITE(EX_REG_WRITE), .EX_RT_FWD(EX_RT_FWD)
    );

    typedef struct {
        logic        rst_n, id_valid;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  shamt, rs_a, rt_a, wr_a;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic [3:0]  op;
        logic        rw, stall, flush;
        logic        mem_rw;
        logic [4:0]  mem_wa;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_wa;
        logic [31:0] wb_res;
    } stim_t;

    typedef struct {
        logic [31:0] a, b, rtf;
        logic [3:0]  op;
        logic        v, rw;
        logic [4:0]  wa;
        logic        chk_data;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference state: the instruction currently sitting in EX, plus its operand values.
    stim_t       m_ins;
    logic [31:0] m_rs, m_rt;
    logic [3:0]  m_op;
    logic [4:0]  m_wa;
    logic        m_valid, m_rw, m_zeroed;

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] regd,
                                            input stim_t s);
`ifdef EX_FWD_EN
        if (a == 5'd0) return regd;
        if (s.mem_rw && s.mem_wa == a) return s.mem_res;
        if (s.wb_rw && s.wb_wa == a) return s.wb_res;
`endif
        return regd;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst_n    = ($urandom_range(0, 49) != 0);
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.rs_d     = $urandom;
        s.rt_d     = $urandom;
        s.imm      = $urandom;
        s.shamt    = 5'($urandom);
        s.rs_a     = 5'($urandom_range(0, 3));
        s.rt_a     = 5'($urandom_range(0, 3));
        s.wr_a     = 5'($urandom);
        s.a_sel    = 1'($urandom);
        s.b_sel    = 2'($urandom);
        s.op       = 4'($urandom);
        s.rw       = 1'($urandom);
        s.stall    = ($urandom_range(0, 4) == 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.mem_rw   = 1'($urandom);
        s.mem_wa   = 5'($urandom_range(0, 3));
        s.mem_res  = $urandom;
        s.wb_rw    = 1'($urandom);
        s.wb_wa    = 5'($urandom_range(0, 3));
        s.wb_res   = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        RST_N = s.rst_n; ID_VALID = s.id_valid;
        ID_RS_DATA = s.rs_d; ID_RT_DATA = s.rt_d; ID_IMM = s.imm;
        ID_SHAMT = s.shamt; ID_RS_ADDR = s.rs_a; ID_RT_ADDR = s.rt_a;
        ID_A_SEL = s.a_sel; ID_B_SEL = s.b_sel; ID_ALU_OP = s.op;
        ID_WR_ADDR = s.wr_a; ID_REG_WRITE = s.rw;
        STALL = s.stall; FLUSH = s.flush;
        MEM_REG_WRITE = s.mem_rw; MEM_WR_ADDR = s.mem_wa; MEM_RESULT = s.mem_res;
        WB_REG_WRITE = s.wb_rw; WB_WR_ADDR = s.wb_wa; WB_RESULT = s.wb_res;
    endtask

    task automatic model_reset();
        m_ins = '{default: '0};
        m_rs = 0; m_rt = 0; m_op = 0; m_wa = 0;
        m_valid = 0; m_rw = 0; m_zeroed = 1;
    endtask

    // Called just after a rising edge: apply s, predict outputs, advance the model at the next edge.
    task automatic step(input stim_t s);
        exp_t e;
        logic [31:0] frs, frt;
        drive(s);
        frs = ref_fwd(m_ins.rs_a, m_rs, s);
        frt = ref_fwd(m_ins.rt_a, m_rt, s);
        e.a   = m_ins.a_sel ? frt : frs;
        case (m_ins.b_sel)
            2'd0: e.b = frt;
            2'd1: e.b = m_ins.imm;
            2'd2: e.b = 32'(m_ins.shamt);
            default: e.b = 32'd0;
        endcase
        e.rtf = frt;
        e.op  = m_op;
        e.v   = m_valid;
        e.rw  = m_rw & m_valid;
        e.wa  = m_wa;
        e.chk_data = m_valid | m_zeroed;
        q.push_back(e);
        @(posedge CLK);
        if (!s.rst_n) begin
            model_reset();
        end else if (s.flush) begin
            m_valid = 0; m_rw = 0; m_op = 0; m_wa = 0; m_zeroed = 0;
        end else if (s.stall) begin
            m_rs = frs;
            m_rt = frt;
        end else begin
            m_ins = s;
            m_rs = s.rs_d; m_rt = s.rt_d;
            m_op = s.op; m_wa = s.wr_a; m_rw = s.rw;
            m_valid = s.id_valid; m_zeroed = 0;
        end
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("ex_valid", 32'(EX_VALID), 32'(e.v));
            cmp("alu_op", 32'(ALU_OP), 32'(e.op));
            cmp("ex_reg_write", 32'(EX_REG_WRITE), 32'(e.rw));
            cmp("ex_wr_addr", 32'(EX_WR_ADDR), 32'(e.wa));
            if (e.chk_data) begin
                cmp("alu_a", ALU_A, e.a);
                cmp("alu_b", ALU_B, e.b);
                cmp("ex_rt_fwd", EX_RT_FWD, e.rtf);
            end
        end
    end

    initial begin
        stim_t s;
        // Reset with busy ID inputs for two edges.
        s = rnd();
        s.rst_n = 1'b0; s.id_valid = 1'b1; s.op = 4'hA; s.rw = 1'b1;
        drive(s);
        @(posedge CLK);
        #1;
        model_reset();
        step(s);

        // add: rs=r3 holding 5, rt=r4 holding 7.
        s = idle();
        s.id_valid = 1; s.rs_a = 3; s.rs_d = 5; s.rt_a = 4; s.rt_d = 7;
        s.op = 4'h8; s.wr_a = 5'd2; s.rw = 1;
        step(s);
        step(idle());

        // Forward priority on rs=r3, then rs=r0.
        for (int z = 0; z < 2; z++) begin
            s = idle();
            s.id_valid = 1; s.rs_a = (z == 0) ? 5'd3 : 5'd0; s.rs_d = 32'h99;
            s.rt_a = 4; s.rt_d = 7; s.op = 4'h8;
            step(s);
            s = idle();
            s.stall = 1;
            s.mem_rw = 1; s.mem_wa = (z == 0) ? 5'd3 : 5'd0; s.mem_res = 32'h11;
            s.wb_rw = 1; s.wb_wa = (z == 0) ? 5'd3 : 5'd0; s.wb_res = 32'h22;
            step(s);
            s.mem_rw = 0;
            step(s);
        end

        // sra with A from rt and B from shamt.
        s = idle();
        s.id_valid = 1; s.op = 4'h3; s.a_sel = 1; s.rt_a = 5'd5;
        s.rt_d = 32'h8000_0000; s.b_sel = 2'd2; s.shamt = 5'd4;
        step(s);
        step(idle());

        // Stall refresh: WB feeds r9 once, then goes idle while stalled.
        s = idle();
        s.id_valid = 1; s.rt_a = 5'd9; s.rt_d = 32'h1; s.op = 4'h8;
        step(s);
        s = rnd();
        s.rst_n = 1; s.flush = 0; s.stall = 1; s.mem_rw = 0;
        s.wb_rw = 1; s.wb_wa = 5'd9; s.wb_res = 32'h55;
        step(s);
        for (int k = 0; k < 2; k++) begin
            s = rnd();
            s.rst_n = 1; s.flush = 0; s.stall = 1; s.mem_rw = 0; s.wb_rw = 0;
            step(s);
        end

        // Flush with stall asserted.
        s = rnd();
        s.rst_n = 1; s.flush = 1; s.stall = 1;
        step(s);
        step(idle());

        for (int n = 0; n < 3000; n++) step(rnd());

        repeat (2) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
